instruction_sequencer: RTL and testbench

Control FSM that sequences the 8-bit register datapath (registers A and B, instruction-byte register, result buffer) of the simple processor. It steps through fetch, decode and execute, and drives the datapath's select, write-enable and memory-source controls plus a program counter used as the memory address. It also runs a memory-ready handshake with a timeout and halts on a HLT opcode or a memory fault.

---
 rtl/instruction_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_instruction_sequencer.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// instruction_sequencer
// Fetch/decode/execute control FSM for the 8-bit register datapath.
// Drives the register select, write enable, A-load source, ALU function and
// buffer strobe, and owns the program counter used as the memory address.
// Memory reads use a mem_ready handshake with a bounded wait; a timeout
// parks the machine in HALT with a sticky fault flag.

module instruction_sequencer #(
    parameter int PC_W    = 8,
    parameter int TIMEOUT = 15
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            mem_ready,
    input  logic [7:0]      instr,
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    output logic [1:0]      seletor,
    output logic            enable,
    output logic            variacao2,
    output logic [1:0]      alu_op,
    output logic            buf_load,
    output logic            busy,
    output logic            halted,
    output logic            fault
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_LOADI  = 4'd2,
        S_DECODE = 4'd3,
        S_OPER   = 4'd4,
        S_LOADA  = 4'd5,
        S_LOADB  = 4'd6,
        S_EXEC   = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    // Register-select codes on the datapath
    localparam logic [1:0] SEL_A   = 2'd0;
    localparam logic [1:0] SEL_B   = 2'd1;
    localparam logic [1:0] SEL_IR  = 2'd2;
    localparam logic [1:0] SEL_BUF = 2'd3;

    // Opcodes in instr[7:6]
    localparam logic [1:0] OP_LDA = 2'b00;
    localparam logic [1:0] OP_LDB = 2'b01;
    localparam logic [1:0] OP_ALU = 2'b10;

    // Wait count value at which one more idle memory cycle means timeout
    localparam logic [7:0]      WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [PC_W-1:0] PC_ONE    = PC_W'(1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [7:0]      r_wait;
    logic            r_fault;
    logic [1:0]      r_seletor;
    logic [1:0]      w_sel_nxt;
    logic            w_pc_inc;
    logic            w_fault_set;
    logic            w_waiting;
    logic            w_wait_last;
    logic [1:0]      w_opcode;
    logic            w_unused_instr;

    assign w_opcode       = instr[7:6];
    assign w_unused_instr = ^instr[3:0];

    // Only FETCH and OPER wait on memory; the last wait cycle is the one
    // where the counter has already seen TIMEOUT-1 idle cycles.
    assign w_waiting   = (r_state == S_FETCH) || (r_state == S_OPER);
    assign w_wait_last = !mem_ready && (r_wait == WAIT_LAST);

    assign mem_addr = r_pc;
    assign seletor  = r_seletor;
    assign fault    = r_fault;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decision and Moore outputs of the current state
    always_comb begin
        w_state_nxt = r_state;
        w_pc_inc    = 1'b0;
        w_fault_set = 1'b0;
        mem_req     = 1'b0;
        enable      = 1'b0;
        variacao2   = 1'b0;
        alu_op      = 2'b00;
        buf_load    = 1'b0;
        busy        = 1'b1;
        halted      = 1'b0;

        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    w_state_nxt = S_LOADI;
                end else if (w_wait_last) begin
                    w_state_nxt = S_HALT;
                    w_fault_set = 1'b1;
                end
            end
            S_LOADI: begin
                enable      = 1'b1;
                w_pc_inc    = 1'b1;
                w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (w_opcode)
                    OP_LDA:  w_state_nxt = S_OPER;
                    OP_LDB:  w_state_nxt = S_LOADB;
                    OP_ALU:  w_state_nxt = S_EXEC;
                    default: w_state_nxt = S_HALT;
                endcase
            end
            S_OPER: begin
                mem_req   = 1'b1;
                variacao2 = 1'b1;
                if (mem_ready) begin
                    w_state_nxt = S_LOADA;
                end else if (w_wait_last) begin
                    w_state_nxt = S_HALT;
                    w_fault_set = 1'b1;
                end
            end
            S_LOADA: begin
                enable      = 1'b1;
                variacao2   = 1'b1;
                w_pc_inc    = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_LOADB: begin
                enable      = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_EXEC: begin
                alu_op      = instr[5:4];
                buf_load    = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Select code for the state being entered; IDLE and HALT keep the last one
    always_comb begin
        w_sel_nxt = r_seletor;
        case (w_state_nxt)
            S_FETCH, S_LOADI, S_DECODE: w_sel_nxt = SEL_IR;
            S_OPER, S_LOADA:            w_sel_nxt = SEL_A;
            S_LOADB:                    w_sel_nxt = SEL_B;
            S_EXEC:                     w_sel_nxt = SEL_BUF;
            default:                    w_sel_nxt = r_seletor;
        endcase
    end

    // Registered select so it lines up with the registered state
    always_ff @(posedge clock) begin
        if (reset) begin
            r_seletor <= SEL_A;
        end else begin
            r_seletor <= w_sel_nxt;
        end
    end

    // Program counter: advances leaving LOADI and LOADA, wraps silently
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc <= '0;
        end else if (w_pc_inc) begin
            r_pc <= r_pc + PC_ONE;
        end
    end

    // Memory wait counter: counts idle cycles in FETCH/OPER, zero elsewhere,
    // so every entry into a wait state starts from zero
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wait <= '0;
        end else if (w_waiting && !mem_ready && !w_wait_last) begin
            r_wait <= r_wait + 8'd1;
        end else begin
            r_wait <= '0;
        end
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else if (w_fault_set) begin
            r_fault <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Testbench for instruction_sequencer: a cycle table for a short program,
// hand sequences for LDA/ALU, timeout, reset and pc wrap, and random
// programs checked against an instruction-level trace generator.

module tb_instruction_sequencer;

    localparam int TIMEOUT = 15;
    localparam int NCYC    = 200;

    logic       clock;
    logic       reset;
    logic       start;
    logic       mem_ready;
    logic [7:0] ir;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic [1:0] seletor;
    logic       enable;
    logic       variacao2;
    logic [1:0] alu_op;
    logic       buf_load;
    logic       busy;
    logic       halted;
    logic       fault;

    logic [7:0] mem [256];

    int total;
    int bad;

    typedef struct packed {
        logic       mem_req;
        logic [7:0] addr;
        logic [1:0] sel;
        logic       en;
        logic       v2;
        logic [1:0] aop;
        logic       bl;
        logic       busy;
        logic       halted;
        logic       fault;
    } outs_t;

    typedef struct {
        logic  rst;
        logic  st;
        logic  rdy;
        outs_t exp;
    } row_t;

    row_t  rows[$];
    outs_t exp_q[$];
    bit    rdy_arr[NCYC];
    int    gt;

    instruction_sequencer #(
        .PC_W   (8),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .mem_ready(mem_ready),
        .instr    (ir),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .seletor  (seletor),
        .enable   (enable),
        .variacao2(variacao2),
        .alu_op   (alu_op),
        .buf_load (buf_load),
        .busy     (busy),
        .halted   (halted),
        .fault    (fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction-byte register of the datapath: loads the memory byte
    // when the sequencer writes with select=instruction byte.
    always @(posedge clock) begin
        if (enable === 1'b1 && seletor == 2'd2) ir <= mem[mem_addr];
    end

    function automatic outs_t mk(int mr, int a, int s, int en, int v2,
                                 int aop, int bl, int bsy, int h, int f);
        outs_t o;
        o.mem_req = 1'(mr);
        o.addr    = 8'(a);
        o.sel     = 2'(s);
        o.en      = 1'(en);
        o.v2      = 1'(v2);
        o.aop     = 2'(aop);
        o.bl      = 1'(bl);
        o.busy    = 1'(bsy);
        o.halted  = 1'(h);
        o.fault   = 1'(f);
        return o;
    endfunction

    function automatic outs_t dut_outs();
        outs_t o;
        o.mem_req = mem_req;
        o.addr    = mem_addr;
        o.sel     = seletor;
        o.en      = enable;
        o.v2      = variacao2;
        o.aop     = alu_op;
        o.bl      = buf_load;
        o.busy    = busy;
        o.halted  = halted;
        o.fault   = fault;
        return o;
    endfunction

    task automatic chk_outs(input string name, input outs_t e);
        outs_t a;
        a = dut_outs();
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h (req,addr,sel,en,v2,aop,bl,busy,halt,fault)",
                     name, a, e);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic add_row(input logic r, input logic s, input logic y, input outs_t e);
        row_t x;
        x.rst = r;
        x.st  = s;
        x.rdy = y;
        x.exp = e;
        rows.push_back(x);
    endtask

    // ---- instruction-level trace generator for random programs ----
    task automatic gpush(input outs_t o);
        if (gt < NCYC) exp_q.push_back(o);
        gt++;
    endtask

    // One memory access: a request cycle per attempt until ready or timeout
    task automatic gwait(input logic [7:0] a, input int s, input int v, output bit ok);
        bit done;
        ok   = 1'b0;
        done = 1'b0;
        for (int w = 1; w <= TIMEOUT && !done && gt < NCYC; w++) begin
            bit r;
            r = rdy_arr[gt];
            gpush(mk(1, int'(a), s, 0, v, 0, 0, 1, 0, 0));
            if (r) begin
                ok   = 1'b1;
                done = 1'b1;
            end
        end
    endtask

    task automatic gen_trace();
        logic [7:0] pc;
        logic [7:0] op;
        int         sel;
        bit         ok;
        bit         halt;
        bit         flt;
        exp_q.delete();
        gt   = 0;
        pc   = 8'h00;
        sel  = 0;
        halt = 1'b0;
        flt  = 1'b0;
        while (!halt && gt < NCYC) begin
            gwait(pc, 2, 0, ok);
            sel = 2;
            if (!ok) begin
                halt = 1'b1;
                flt  = 1'b1;
            end else begin
                gpush(mk(0, int'(pc), 2, 1, 0, 0, 0, 1, 0, 0));
                op = mem[pc];
                pc = pc + 8'd1;
                gpush(mk(0, int'(pc), 2, 0, 0, 0, 0, 1, 0, 0));
                case (op[7:6])
                    2'b00: begin
                        gwait(pc, 0, 1, ok);
                        sel = 0;
                        if (!ok) begin
                            halt = 1'b1;
                            flt  = 1'b1;
                        end else begin
                            gpush(mk(0, int'(pc), 0, 1, 1, 0, 0, 1, 0, 0));
                            pc = pc + 8'd1;
                        end
                    end
                    2'b01: begin
                        gpush(mk(0, int'(pc), 1, 1, 0, 0, 0, 1, 0, 0));
                        sel = 1;
                    end
                    2'b10: begin
                        gpush(mk(0, int'(pc), 3, 0, 0, int'(op[5:4]), 1, 1, 0, 0));
                        sel = 3;
                    end
                    default: halt = 1'b1;
                endcase
            end
        end
        while (gt < NCYC) gpush(mk(0, int'(pc), sel, 0, 0, 0, 0, 0, 1, int'(flt)));
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        start     = 1'b0;
        mem_ready = 1'b0;
        ir        = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // ---- table: LDB then HLT with mem_ready high ----
        mem[0] = 8'h40;
        mem[1] = 8'hC0;
        add_row(1, 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // reset -> IDLE
        add_row(0, 1, 1, mk(1, 0, 2, 0, 0, 0, 0, 1, 0, 0)); // FETCH
        add_row(0, 0, 1, mk(0, 0, 2, 1, 0, 0, 0, 1, 0, 0)); // LOADI
        add_row(0, 0, 1, mk(0, 1, 2, 0, 0, 0, 0, 1, 0, 0)); // DECODE
        add_row(0, 1, 1, mk(0, 1, 1, 1, 0, 0, 0, 1, 0, 0)); // LOADB, start ignored
        add_row(0, 0, 1, mk(1, 1, 2, 0, 0, 0, 0, 1, 0, 0)); // FETCH
        add_row(0, 0, 1, mk(0, 1, 2, 1, 0, 0, 0, 1, 0, 0)); // LOADI
        add_row(0, 0, 1, mk(0, 2, 2, 0, 0, 0, 0, 1, 0, 0)); // DECODE
        add_row(0, 0, 1, mk(0, 2, 2, 0, 0, 0, 0, 0, 1, 0)); // HALT (cycle 7)
        add_row(0, 1, 1, mk(0, 2, 2, 0, 0, 0, 0, 0, 1, 0)); // HALT holds
        add_row(1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // reset leaves HALT
        for (int i = 0; i < rows.size(); i++) begin
            reset     = rows[i].rst;
            start     = rows[i].st;
            mem_ready = rows[i].rdy;
            step();
            chk_outs($sformatf("table_row%0d", i), rows[i].exp);
        end

        // ---- LDA at 0x10, ALU op 2, HLT; start pulses while busy ----
        for (int i = 0; i < 16; i++) mem[i] = 8'h40;
        mem[16] = 8'h00;
        mem[17] = 8'h55;
        mem[18] = 8'hA0;
        mem[19] = 8'hC0;
        do_reset();
        mem_ready = 1'b1;
        start = 1'b1;
        step();
        for (int i = 0; i < 64; i++) begin
            start = 1'($urandom_range(0, 1));
            step();
        end
        chk_outs("lda_fetch10", mk(1, 8'h10, 2, 0, 0, 0, 0, 1, 0, 0));
        step(); chk_outs("lda_loadi",   mk(0, 8'h10, 2, 1, 0, 0, 0, 1, 0, 0));
        step(); chk_outs("lda_decode",  mk(0, 8'h11, 2, 0, 0, 0, 0, 1, 0, 0));
        step(); chk_outs("lda_oper",    mk(1, 8'h11, 0, 0, 1, 0, 0, 1, 0, 0));
        step(); chk_outs("lda_loada",   mk(0, 8'h11, 0, 1, 1, 0, 0, 1, 0, 0));
        step(); chk_outs("lda_fetch12", mk(1, 8'h12, 2, 0, 0, 0, 0, 1, 0, 0));
        step(); step();
        step(); chk_outs("alu_exec",    mk(0, 8'h13, 3, 0, 0, 2, 1, 1, 0, 0));
        step(); chk_outs("alu_after",   mk(1, 8'h13, 2, 0, 0, 0, 0, 1, 0, 0));
        step(); step();
        step(); chk_outs("hlt_halt",    mk(0, 8'h14, 2, 0, 0, 0, 0, 0, 1, 0));
        start = 1'b0;

        // ---- reset in the middle of OPER ----
        mem[0] = 8'h00;
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        chk_outs("mid_oper", mk(1, 1, 0, 0, 1, 0, 0, 1, 0, 0));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_outs("mid_oper_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // ---- FETCH timeout: 15 idle cycles -> HALT with fault ----
        mem[0] = 8'h40;
        do_reset();
        mem_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk_outs("to_wait1", mk(1, 0, 2, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 0; i < 14; i++) step();
        chk_outs("to_wait15", mk(1, 0, 2, 0, 0, 0, 0, 1, 0, 0));
        step();
        chk_outs("to_halt", mk(0, 0, 2, 0, 0, 0, 0, 0, 1, 1));
        start = 1'b1;
        mem_ready = 1'b1;
        step();
        start = 1'b0;
        chk_outs("to_halt_sticky", mk(0, 0, 2, 0, 0, 0, 0, 0, 1, 1));

        // ---- mem_ready arrives on the 15th wait cycle ----
        do_reset();
        chk_outs("rdy15_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        mem_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 14; i++) step();
        chk_outs("rdy15_wait15", mk(1, 0, 2, 0, 0, 0, 0, 1, 0, 0));
        mem_ready = 1'b1;
        step();
        chk_outs("rdy15_loadi", mk(0, 0, 2, 1, 0, 0, 0, 1, 0, 0));

        // ---- pc wrap: LDB at 0xFF ----
        for (int i = 0; i < 256; i++) mem[i] = 8'h40;
        do_reset();
        mem_ready = 1'b1;
        start = 1'b1;
        step();
        for (int i = 0; i < 255 * 4; i++) begin
            start = 1'($urandom_range(0, 1));
            step();
        end
        start = 1'b0;
        chk_outs("wrap_fetchff", mk(1, 8'hFF, 2, 0, 0, 0, 0, 1, 0, 0));
        step(); chk_outs("wrap_loadi",  mk(0, 8'hFF, 2, 1, 0, 0, 0, 1, 0, 0));
        step(); chk_outs("wrap_decode", mk(0, 8'h00, 2, 0, 0, 0, 0, 1, 0, 0));
        step(); chk_outs("wrap_loadb",  mk(0, 8'h00, 1, 1, 0, 0, 0, 1, 0, 0));
        step(); chk_outs("wrap_fetch0", mk(1, 8'h00, 2, 0, 0, 0, 0, 1, 0, 0));

        // ---- random programs and random memory latency ----
        for (int trial = 0; trial < 12; trial++) begin
            int pct;
            case (trial % 4)
                0:       pct = 100;
                1:       pct = 80;
                2:       pct = 45;
                default: pct = 3;
            endcase
            for (int i = 0; i < 256; i++) begin
                int r;
                r = int'($urandom_range(0, 99));
                mem[i][5:0] = 6'($urandom);
                if (r < 30)      mem[i][7:6] = 2'b00;
                else if (r < 60) mem[i][7:6] = 2'b01;
                else if (r < 93) mem[i][7:6] = 2'b10;
                else             mem[i][7:6] = 2'b11;
            end
            for (int t = 0; t < NCYC; t++) rdy_arr[t] = (int'($urandom_range(0, 99)) < pct);
            gen_trace();
            do_reset();
            start = 1'b1;
            step();
            for (int t = 0; t < NCYC; t++) begin
                chk_outs($sformatf("rand_t%0d_c%0d", trial, t), exp_q[t]);
                mem_ready = rdy_arr[t];
                start = 1'($urandom_range(0, 1));
                step();
            end
            start = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
